fp_multiplier: RTL
==================

# fp_multiplier

Multi-cycle IEEE-754 single-precision multiplier for the GRU-RNN equalizer datapath. It sits directly upstream of `fp_adder`: its `prod`/`ready` outputs drive the adder's `opa`/`start` in the gate multiply-accumulate chains. Its start/ready handshake is identical to the adder's, so the two chain without glue logic. It supports round-to-nearest-even only, with full handling of denormals, zero, infinity and NaN.

## Interface
- No parameters.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `opa`  in  32  operand A, IEEE-754 single; sampled only when `start` is seen in WAIT.
- `opb`  in  32  operand B, sampled with `opa`.
- `start`  in  1  request; ignored in every state except WAIT.
- `prod`  out  32  result register; holds its value until the next result is written.
- `ready`  out  1  single-cycle pulse; high for exactly one cycle, in the same cycle that a new `prod` becomes visible.

## Operation
- State sequence: WAIT, UNPACK, SPECIAL, NORM_A, NORM_B, MUL_0, MUL_1, NORMALISE_1, NORMALISE_2, ROUND, PACK, OUT_RDY, then back to WAIT.
- **WAIT:** drive `ready`=0. If `start`=1, latch `opa` and `opb`.
- **UNPACK:**
  - mantissas become 24-bit `{0, m[22:0]}`;
  - exponents become 10-bit signed `e-127`;
  - signs are captured.
- **SPECIAL:** the result sign is `sa^sb` unless stated otherwise. Cases in priority order; each goes straight to OUT_RDY:
  - either operand NaN → 0xFFC00000;
  - infinity × zero, in either order → 0xFFC00000;
  - either operand infinity → {s, 0xFF, 0};
  - either operand zero → {s, 0x00, 0}.
- Otherwise, in SPECIAL:
  - an operand with exponent field 0 gets exponent -126 and hidden bit 0;
  - any other operand gets hidden bit 1.
- **NORM_A / NORM_B:** while mantissa bit 23 = 0, shift the mantissa left 1 and decrement the exponent, one shift per cycle. Exit when bit 23 = 1.
- **MUL_0:**
  - 48-bit product = `ma*mb`;
  - `z_e = ea+eb+1`.
- **MUL_1:**
  - `z_m = p[47:24]`;
  - guard = `p[23]`;
  - round = `p[22]`;
  - sticky = OR of `p[21:0]`.
- **NORMALISE_1:** while `z_m[23]`=0 and `z_e` > -126, do one left shift per cycle:
  - `z_e`-1;
  - `z_m[0]` takes guard;
  - guard takes round;
  - round is cleared.
- **NORMALISE_2:** while `z_e` < -126, do one right shift per cycle:
  - `z_e`+1;
  - guard takes `z_m[0]`;
  - round takes guard;
  - sticky ORs in round.
- **ROUND:** if guard AND (round OR sticky OR `z_m[0]`), increment `z_m`. If `z_m` was 0xFFFFFF, also increment `z_e`.
- **PACK:**
  - exponent field = `z_e[7:0]+127`;
  - if `z_e` = -126 and `z_m[23]`=0, exponent field = 0 (denormal or zero);
  - if `z_e` > 127, result = {s, 0xFF, 0} (overflow to infinity);
  - an underflow to all-zero mantissa keeps sign `sa^sb`.
- **OUT_RDY:** `prod` ← z; `ready` ← 1; go to WAIT.
- Exponent arithmetic is 10-bit two's complement throughout and has no wrap for any legal inputs.

## Timing
- Reset values: `ready`=0, `prod`=0x00000000, state = WAIT. Asserting `rst` in any state aborts the operation immediately: no `ready` pulse follows, and `prod` goes to 0.
- Latency is counted in rising edges from the edge that samples `start` to the edge that raises `ready`:
  - 11 for normal operands needing no normalise shifts;
  - 3 for special cases.
- Each shift in NORM_A, NORM_B, NORMALISE_1 or NORMALISE_2 adds 1 cycle.
- `start` held high continuously: the next operation begins on the cycle after `ready` falls, i.e. the first WAIT cycle.
- `start` asserted while busy has no effect and is not queued.
- Changes on `opa`/`opb` after sampling do not affect the result in flight.

## Test plan
- 0x40000000 × 0x40400000 → `prod`=0x40C00000; `ready` rises 11 edges after start; `ready` is high 1 cycle.
- 0xBFC00000 × 0x40000000 → 0xC0400000; and 0x3F800001 × 0x3F800001 → 0x3F800002 (round-to-nearest-even).
- Specials:
  - 0x7F800000 × 0x00000000 → 0xFFC00000;
  - 0x7F800000 × 0xC0000000 → 0xFF800000;
  - 0x7FC00000 × 0x3F800000 → 0xFFC00000;
  - 0x80000000 × 0x40000000 → 0x80000000;
  - each with `ready` rising 3 edges after start.
- Denormal and limits:
  - 0x00000001 × 0x4B000000 → 0x00800000;
  - 0x00800000 × 0x3F000000 → 0x00400000;
  - 0x7F000000 × 0x40000000 → 0x7F800000.
- Handshake: pulse `start` again during MUL_0 → ignored; exactly one `ready` pulse occurs and `prod` is the first result. Then hold `start` high → back-to-back results with `ready` pulses 12 cycles apart.
- Reset mid-operation: drop `rst` in NORMALISE_1 → `ready`=0 and `prod`=0 immediately. After release, no `ready` pulse occurs until a new `start`, and the new operation completes correctly.

Source files
------------

// File: rtl/fp_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : fp_multiplier
// Brief    : Multi-cycle IEEE-754 single-precision multiplier with start/ready
//            handshake, round-to-nearest-even, and denormal/zero/inf/NaN
//            handling. Chains directly into fp_adder.
// Revision : 1.0 - initial release
// ============================================================================
module fp_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        start,
  output logic [31:0] prod,
  output logic        ready
);

  typedef enum logic [3:0] {
    ST_WAIT        = 4'd0,
    ST_UNPACK      = 4'd1,
    ST_SPECIAL     = 4'd2,
    ST_NORM_A      = 4'd3,
    ST_NORM_B      = 4'd4,
    ST_MUL_0       = 4'd5,
    ST_MUL_1       = 4'd6,
    ST_NORMALISE_1 = 4'd7,
    ST_NORMALISE_2 = 4'd8,
    ST_ROUND       = 4'd9,
    ST_PACK        = 4'd10,
    ST_OUT_RDY     = 4'd11
  } state_t;

  // Unbiased exponent landmarks in 10-bit two's complement
  localparam logic signed [9:0] E_MIN = -10'sd126;  // smallest normal exponent
  localparam logic signed [9:0] E_DEN = -10'sd127;  // field 0 after unbiasing
  localparam logic signed [9:0] E_INF =  10'sd128;  // field 0xFF after unbiasing
  localparam logic signed [9:0] E_MAX =  10'sd127;  // largest normal exponent
  localparam logic [31:0]       QNAN  = 32'hFFC00000;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d;
  logic [47:0]        p_q, p_d;
  logic [23:0]        z_m_q, z_m_d;
  logic signed [9:0]  z_e_q, z_e_d;
  logic               z_s_q, z_s_d;
  logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [31:0]        z_q, z_d;
  logic [31:0]        prod_q, prod_d;
  logic               ready_q, ready_d;

  // Operand classification on the unpacked fields (valid in SPECIAL)
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (a_e_q == E_INF) && (a_m_q != 24'd0);
  assign b_nan  = (b_e_q == E_INF) && (b_m_q != 24'd0);
  assign a_inf  = (a_e_q == E_INF) && (a_m_q == 24'd0);
  assign b_inf  = (b_e_q == E_INF) && (b_m_q == 24'd0);
  assign a_zero = (a_e_q == E_DEN) && (a_m_q == 24'd0);
  assign b_zero = (b_e_q == E_DEN) && (b_m_q == 24'd0);

  // Next-state and datapath updates for every step of the multiply sequence
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    p_d      = p_q;
    z_m_d    = z_m_q;
    z_e_d    = z_e_q;
    z_s_d    = z_s_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    prod_d   = prod_q;
    ready_d  = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (start) begin
          a_d     = opa;
          b_d     = opb;
          state_d = ST_UNPACK;
        end
      end

      ST_UNPACK: begin
        a_m_d   = {1'b0, a_q[22:0]};
        b_m_d   = {1'b0, b_q[22:0]};
        a_e_d   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        b_e_d   = $signed({2'b00, b_q[30:23]}) - 10'sd127;
        a_s_d   = a_q[31];
        b_s_d   = b_q[31];
        state_d = ST_SPECIAL;
      end

      ST_SPECIAL: begin
        z_s_d = a_s_q ^ b_s_q;
        if (a_nan || b_nan) begin
          z_d     = QNAN;
          state_d = ST_OUT_RDY;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
          z_d     = QNAN;
          state_d = ST_OUT_RDY;
        end else if (a_inf || b_inf) begin
          z_d     = {a_s_q ^ b_s_q, 8'hFF, 23'd0};
          state_d = ST_OUT_RDY;
        end else if (a_zero || b_zero) begin
          z_d     = {a_s_q ^ b_s_q, 31'd0};
          state_d = ST_OUT_RDY;
        end else begin
          // Denormals share the minimum exponent and have no hidden bit
          if (a_e_q == E_DEN) a_e_d = E_MIN;
          else                a_m_d[23] = 1'b1;
          if (b_e_q == E_DEN) b_e_d = E_MIN;
          else                b_m_d[23] = 1'b1;
          state_d = ST_NORM_A;
        end
      end

      ST_NORM_A: begin
        if (a_m_q[23]) begin
          state_d = ST_NORM_B;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end
      end

      ST_NORM_B: begin
        if (b_m_q[23]) begin
          state_d = ST_MUL_0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end
      end

      ST_MUL_0: begin
        // Product has its binary point at bit 46; the +1 aligns it to bit 47
        p_d     = {24'd0, a_m_q} * {24'd0, b_m_q};
        z_e_d   = a_e_q + b_e_q + 10'sd1;
        state_d = ST_MUL_1;
      end

      ST_MUL_1: begin
        z_m_d    = p_q[47:24];
        guard_d  = p_q[23];
        round_d  = p_q[22];
        sticky_d = |p_q[21:0];
        state_d  = ST_NORMALISE_1;
      end

      ST_NORMALISE_1: begin
        if (!z_m_q[23] && (z_e_q > E_MIN)) begin
          z_e_d   = z_e_q - 10'sd1;
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
        end else begin
          state_d = ST_NORMALISE_2;
        end
      end

      ST_NORMALISE_2: begin
        if (z_e_q < E_MIN) begin
          z_e_d    = z_e_q + 10'sd1;
          z_m_d    = {1'b0, z_m_q[23:1]};
          guard_d  = z_m_q[0];
          round_d  = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        // Round half to even; a mantissa carry-out bumps the exponent
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
        end
        state_d = ST_PACK;
      end

      ST_PACK: begin
        z_d[22:0]  = z_m_q[22:0];
        z_d[30:23] = z_e_q[7:0] + 8'd127;
        z_d[31]    = z_s_q;
        if ((z_e_q == E_MIN) && !z_m_q[23]) z_d[30:23] = 8'd0;
        if (z_e_q > E_MAX) z_d = {z_s_q, 8'hFF, 23'd0};
        state_d = ST_OUT_RDY;
      end

      ST_OUT_RDY: begin
        prod_d  = z_q;
        ready_d = 1'b1;
        state_d = ST_WAIT;
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // State and datapath registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      a_m_q    <= 24'd0;
      b_m_q    <= 24'd0;
      a_e_q    <= 10'sd0;
      b_e_q    <= 10'sd0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      p_q      <= 48'd0;
      z_m_q    <= 24'd0;
      z_e_q    <= 10'sd0;
      z_s_q    <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= 32'd0;
      prod_q   <= 32'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      p_q      <= p_d;
      z_m_q    <= z_m_d;
      z_e_q    <= z_e_d;
      z_s_q    <= z_s_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      prod_q   <= prod_d;
      ready_q  <= ready_d;
    end
  end

  assign prod  = prod_q;
  assign ready = ready_q;

endmodule
`default_nettype wire
